// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory constants and loader state type
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/word_byte_sel.sv
// rtl/word_byte_sel.sv - little-endian byte lane select from an instruction word
import imem_pkg::*;

module word_byte_sel (
    input  logic [INSTR_W-1:0] word,
    input  logic [1:0]         lane,
    output logic [BYTE_W-1:0]  sel_byte
);

    // Lane 0 is the least significant byte so fetch reassembles {M[a+3]..M[a]}
    always_comb begin
        sel_byte = word[BYTE_W-1:0];
        case (lane)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time writer splitting stream words into byte writes
import imem_pkg::*;

module imem_loader #(
    parameter int MEM_BYTES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               word_valid,
    input  logic [INSTR_W-1:0] word_data,
    input  logic               word_last,
    output logic               word_ready,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0]  mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               overflow
);

    localparam int AW = $clog2(MEM_BYTES);
    // One extra bit so the pointer can represent "one past the end"
    localparam int PW = AW + 1;

    loader_state_t      state, state_n;
    logic [PW-1:0]      ptr, ptr_n, ptr_next_word;
    logic [1:0]         lane, lane_n;
    logic [INSTR_W-1:0] word_q, word_n;
    logic               last_q, last_n;
    logic               ovf_q, ovf_n;
    logic [AW-1:0]      byte_addr;
    logic [BYTE_W-1:0]  lane_byte;

    assign ptr_next_word = ptr + PW'(BYTES_PER_WORD);
    assign byte_addr     = ptr[AW-1:0] + AW'(lane);

    word_byte_sel u_byte_sel (
        .word     (word_q),
        .lane     (lane),
        .sel_byte (lane_byte)
    );

    // State register; async reset drops straight back to IDLE from anywhere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: word pointer, lane counter, captured word and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            lane   <= '0;
            word_q <= '0;
            last_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ptr    <= ptr_n;
            lane   <= lane_n;
            word_q <= word_n;
            last_q <= last_n;
            ovf_q  <= ovf_n;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        lane_n  = lane;
        word_n  = word_q;
        last_n  = last_q;
        ovf_n   = ovf_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    ptr_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            ST_LOAD: begin
                // word_ready is 1 throughout LOAD, so valid alone completes the handshake
                if (word_valid) begin
                    word_n  = word_data;
                    last_n  = word_last;
                    lane_n  = 2'd0;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                lane_n = lane + 2'd1;
                if (lane == 2'd3) begin
                    ptr_n = ptr_next_word;
                    // A last word that fills the final slot is a clean finish, not an overflow
                    if (last_q) begin
                        state_n = ST_DONE;
                    end else if (ptr_next_word == PW'(MEM_BYTES)) begin
                        state_n = ST_DONE;
                        ovf_n   = 1'b1;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    ptr_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; address/data forced to 0 outside WRITE
    always_comb begin
        word_ready = (state == ST_LOAD);
        mem_we     = (state == ST_WRITE);
        done       = (state == ST_DONE);
        cpu_hold   = (state != ST_DONE);
        overflow   = ovf_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state == ST_WRITE) begin
            mem_addr  = {{(INSTR_W-AW){1'b0}}, byte_addr};
            mem_wdata = lane_byte;
        end
    end

endmodule
